msrv32_dmem_load_ctrl: RTL

MSRV32_DMEM_LOAD_CTRL -- requirements
Module: msrv32_dmem_load_ctrl

---
 rtl/msrv32_dmem_load_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/msrv32_dmem_load_ctrl.sv
// Data-memory load controller: captures a stage-3 load, issues a word-aligned
// read, waits (bounded) for the read-data strobe, then aligns/extends the
// returned word and raises a single-cycle register-file write.
// Misaligned accesses and bus timeouts end in a one-cycle FAULT state with a
// cause strobe and no register-file write.
module msrv32_dmem_load_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        load_req_in,
    input  logic [31:0] iadder_out_in,
    input  logic [1:0]  load_size_in,
    input  logic        load_unsigned_in,
    input  logic [4:0]  rd_addr_in,
    input  logic [31:0] dmem_rdata_in,
    input  logic        dmem_ack_in,
    output logic        dmem_req_out,
    output logic [31:0] dmem_addr_out,
    output logic [31:0] lu_output_out,
    output logic        rf_wr_en_out,
    output logic [4:0]  rd_addr_out,
    output logic        stall_out,
    output logic        misaligned_out,
    output logic        timeout_out
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WB,
        FAULT
    } state_t;

    // Last wait-counter value before the timeout is declared; REQ therefore
    // lasts at most TIMEOUT_CYCLES cycles.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [4:0]  rd_q, rd_d;
    logic [7:0]  wait_q, wait_d;
    logic [31:0] lu_q, lu_d;
    logic        to_q, to_d;          // fault cause: 1 = timeout, 0 = misaligned

    logic        req_misaligned;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_ext;

    // Misalignment of the incoming request, judged on the live inputs in IDLE.
    always_comb begin
        req_misaligned = 1'b0;
        case (load_size_in)
            2'b00:   req_misaligned = 1'b0;
            2'b01:   req_misaligned = iadder_out_in[0];
            default: req_misaligned = |iadder_out_in[1:0];
        endcase
    end

    // Select byte/half/word from the read word and extend per the captured flag.
    always_comb begin
        byte_v   = '0;
        half_v   = '0;
        load_ext = '0;
        case (addr_q[1:0])
            2'b00:   byte_v = dmem_rdata_in[7:0];
            2'b01:   byte_v = dmem_rdata_in[15:8];
            2'b10:   byte_v = dmem_rdata_in[23:16];
            default: byte_v = dmem_rdata_in[31:24];
        endcase
        half_v = addr_q[1] ? dmem_rdata_in[31:16] : dmem_rdata_in[15:0];
        case (size_q)
            2'b00:   load_ext = {{24{~uns_q & byte_v[7]}}, byte_v};
            2'b01:   load_ext = {{16{~uns_q & half_v[15]}}, half_v};
            default: load_ext = dmem_rdata_in;
        endcase
    end

    // Next-state logic: capture in IDLE, bounded wait in REQ, single-cycle WB/FAULT.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        uns_d   = uns_q;
        rd_d    = rd_q;
        wait_d  = wait_q;
        lu_d    = lu_q;
        to_d    = to_q;
        case (state_q)
            IDLE: begin
                if (load_req_in) begin
                    addr_d = iadder_out_in;
                    size_d = load_size_in;
                    uns_d  = load_unsigned_in;
                    rd_d   = rd_addr_in;
                    wait_d = '0;
                    if (req_misaligned) begin
                        to_d    = 1'b0;
                        state_d = FAULT;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                // Ack wins over the timeout limit reached in the same cycle.
                if (dmem_ack_in) begin
                    lu_d    = load_ext;
                    state_d = WB;
                end else if (wait_q == WAIT_LAST) begin
                    to_d    = 1'b1;
                    state_d = FAULT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and capture registers; reset returns everything to zero/IDLE at once.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q <= IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            rd_q    <= '0;
            wait_q  <= '0;
            lu_q    <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            rd_q    <= rd_d;
            wait_q  <= wait_d;
            lu_q    <= lu_d;
            to_q    <= to_d;
        end
    end

    assign dmem_req_out   = (state_q == REQ);
    assign dmem_addr_out  = {addr_q[31:2], 2'b00};
    assign lu_output_out  = lu_q;
    assign rd_addr_out    = rd_q;
    assign rf_wr_en_out   = (state_q == WB) && (rd_q != 5'd0);
    assign misaligned_out = (state_q == FAULT) && !to_q;
    assign timeout_out    = (state_q == FAULT) && to_q;
    // Gated by reset so the combinational IDLE term cannot leak through it.
    assign stall_out      = !reset_in && ((state_q != IDLE) || load_req_in);

endmodule
